// File: rtl/moonbase_mem_bridge.sv
// Bridge from the moonbase_cpu_8bit multiplexed I/O bus to a single-port byte memory.
// Decodes address/write phases, arbitrates one memory port and keeps a one-byte read buffer coherent.
module moonbase_mem_bridge #(
    parameter int ADDR_HALF = 6,
    parameter int TIMEOUT   = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             cpu_out,
    output logic [3:0]             cpu_nibble,
    output logic [2*ADDR_HALF-1:0] mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   mem_we,
    output logic                   mem_re,
    input  logic [7:0]             mem_rdata,
    input  logic                   mem_rvalid,
    output logic                   rd_busy,
    output logic                   err_timeout
);

    localparam int AW = 2 * ADDR_HALF;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_HALF-1:0] addr_hi_q, addr_hi_d;
    logic [ADDR_HALF-1:0] addr_lo_q, addr_lo_d;
    logic [3:0]           wtmp_q, wtmp_d;
    logic [7:0]           rbuf_q, rbuf_d;
    logic                 dirty_q, dirty_d;
    logic                 discard_q, discard_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        cnt_inc;
    logic                 err_q, err_d;
    logic [AW-1:0]        mem_addr_q, mem_addr_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;
    logic                 mem_we_q, mem_we_d;
    logic                 mem_re_q, mem_re_d;
    logic                 take_rdata;

    logic       addr_lo_hit, addr_hi_hit, wlo_hit, whi_hit;
    logic [7:0] wbyte;
    logic       unused_data_strobe;

    assign addr_lo_hit        = cpu_out[7] & ~cpu_out[6];
    assign addr_hi_hit        = cpu_out[7] &  cpu_out[6];
    assign wlo_hit            = ~cpu_out[7] & ~cpu_out[5] & ~cpu_out[6];
    assign whi_hit            = ~cpu_out[7] & ~cpu_out[5] &  cpu_out[6];
    assign wbyte              = {cpu_out[3:0], wtmp_q};
    assign unused_data_strobe = cpu_out[4];
    assign cnt_inc            = cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_hi_q   <= '0;
            addr_lo_q   <= '0;
            wtmp_q      <= '0;
            rbuf_q      <= '0;
            dirty_q     <= 1'b1;
            discard_q   <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_hi_q   <= addr_hi_d;
            addr_lo_q   <= addr_lo_d;
            wtmp_q      <= wtmp_d;
            rbuf_q      <= rbuf_d;
            dirty_q     <= dirty_d;
            discard_q   <= discard_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
        end
    end

    // REQ leaves only once its read has actually been on the port (mem_re_q).
    always_comb begin
        state_d    = state_q;
        dirty_d    = dirty_q;
        discard_d  = discard_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        take_rdata = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dirty_q) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_re_q) begin
                    state_d = S_WAIT;
                    dirty_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    take_rdata = ~discard_q & ~dirty_q;
                    discard_d  = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_C) begin
                        err_d     = 1'b1;
                        dirty_d   = 1'b1;
                        discard_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A write landing while a read is in flight makes that read's data stale.
        if (whi_hit && (state_d == S_WAIT)) begin
            discard_d = 1'b1;
        end
        if (addr_lo_hit || addr_hi_hit) begin
            dirty_d = 1'b1;
        end
    end

    assign addr_lo_d   = addr_lo_hit ? cpu_out[ADDR_HALF-1:0] : addr_lo_q;
    assign addr_hi_d   = addr_hi_hit ? cpu_out[ADDR_HALF-1:0] : addr_hi_q;
    assign wtmp_d      = wlo_hit ? cpu_out[3:0] : wtmp_q;
    assign rbuf_d      = whi_hit ? wbyte : (take_rdata ? mem_rdata : rbuf_q);
    assign mem_wdata_d = whi_hit ? wbyte : mem_wdata_q;
    assign mem_addr_d  = {addr_hi_d, addr_lo_d};
    assign mem_we_d    = whi_hit;

    // Writes own the port; a pending read simply waits in REQ.
    always_comb begin
        mem_re_d    = (state_d == S_REQ) && !whi_hit;
        rd_busy     = (state_q != S_IDLE) || dirty_q;
        cpu_nibble  = cpu_out[6] ? rbuf_q[3:0] : rbuf_q[7:4];
        mem_addr    = mem_addr_q;
        mem_wdata   = mem_wdata_q;
        mem_we      = mem_we_q;
        mem_re      = mem_re_q;
        err_timeout = err_q;
    end

endmodule

// File: tb/tb_moonbase_mem_bridge.sv
// Directed bench for moonbase_mem_bridge with a variable-latency byte memory model.
module tb_moonbase_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cpu_out;
    logic [3:0]  cpu_nibble;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic        rd_busy;
    logic        err_timeout;

    moonbase_mem_bridge #(.ADDR_HALF(6), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_out     (cpu_out),
        .cpu_nibble  (cpu_nibble),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .rd_busy     (rd_busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Memory model: return arrives lat cycles after the read command cycle.
    logic [7:0] mem [0:4095];
    int         lat;
    logic       mute;
    logic       force_rv;
    int         pend = 0;
    logic [7:0] rdat = 8'h00;
    logic       mrv  = 1'b0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) begin
            pend <= lat - 1;
            rdat <= mem[mem_addr];
            mrv  <= (lat == 1);
        end else if (pend > 0) begin
            pend <= pend - 1;
            mrv  <= (pend == 1);
        end else begin
            mrv <= 1'b0;
        end
    end

    assign mem_rvalid = (mrv && !mute) || force_rv;
    assign mem_rdata  = force_rv ? 8'hEE : rdat;

    int          re_count = 0;
    int          we_count = 0;
    int          overlap  = 0;
    logic [11:0] last_re_addr = '0;
    logic [7:0]  last_wdata   = '0;

    always @(posedge clk) begin
        if (mem_re) begin
            re_count++;
            last_re_addr = mem_addr;
        end
        if (mem_we) begin
            we_count++;
            last_wdata = mem_wdata;
        end
        if (mem_re && mem_we) overlap++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        else begin
            n_pass++;
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic bus_put(input logic [7:0] v);
        cpu_out = v;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (rd_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_budget", 32'(rd_busy), 0);
    endtask

    task automatic chk_nibbles(input string tag, input logic [7:0] exp);
        cpu_out = 8'h20;
        #1 chk({tag, "_hi"}, 32'(cpu_nibble), 32'(exp[7:4]));
        cpu_out = 8'h60;
        #1 chk({tag, "_lo"}, 32'(cpu_nibble), 32'(exp[3:0]));
        cpu_out = 8'h20;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int base_re;
    int base_we;

    initial begin
        cpu_out  = 8'h20;
        rst      = 1'b1;
        lat      = 1;
        mute     = 1'b0;
        force_rv = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        mem[12'h000] <= 8'hA5;
        mem[12'h4B3] <= 8'h11;
        mem[12'h4B4] <= 8'h3C;
        mem[12'h4B5] <= 8'h5E;
        mem[12'h4B6] <= 8'h42;
        @(negedge clk);
        @(negedge clk);

        chk("rst_mem_re",    32'(mem_re), 0);
        chk("rst_mem_we",    32'(mem_we), 0);
        chk("rst_mem_addr",  32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_err",       32'(err_timeout), 0);
        chk("rst_nibble",    32'(cpu_nibble), 0);
        chk("rst_busy",      32'(rd_busy), 1);

        // Automatic read of address 0 after reset
        base_re = re_count;
        rst = 1'b0;
        wait_idle(20);
        chk("boot_re_count", 32'(re_count - base_re), 1);
        chk("boot_re_addr",  32'(last_re_addr), 32'h000);
        chk_nibbles("boot_rbuf", 8'hA5);

        // ADDR_HI 0x12, ADDR_LO 0x34 -> 0x4B4, a single read
        base_re = re_count;
        bus_put(8'hD2);
        bus_put(8'hB4);
        cpu_out = 8'h20;
        wait_idle(20);
        chk("addr_re_count", 32'(re_count - base_re), 1);
        chk("addr_re_addr",  32'(last_re_addr), 32'h4B4);
        chk_nibbles("addr_rbuf", 8'h3C);

        // Read latency: latch at edge N, mem_re during the cycle after edge N+1
        bus_put(8'hB4);
        cpu_out = 8'h20;
        chk("lat_re_n",   32'(mem_re), 0);
        @(negedge clk);
        chk("lat_re_n1",  32'(mem_re), 1);
        chk("lat_re_adr", 32'(mem_addr), 32'h4B4);
        wait_idle(20);

        // WLO 0x7, WHI 0x9 at 0x4B4
        base_we = we_count;
        bus_put(8'h07);
        bus_put(8'h49);
        chk("wr_we",      32'(mem_we), 1);
        chk("wr_wdata",   32'(mem_wdata), 32'h97);
        chk("wr_addr",    32'(mem_addr), 32'h4B4);
        chk("wr_no_re",   32'(mem_re), 0);
        chk("wr_nib_lo",  32'(cpu_nibble), 32'h7);
        cpu_out = 8'h20;
        #1 chk("wr_nib_hi", 32'(cpu_nibble), 32'h9);
        @(negedge clk);
        chk("wr_we_pulse", 32'(mem_we), 0);
        chk("wr_count",    32'(we_count - base_we), 1);
        chk("wr_mem",      32'(mem[12'h4B4]), 32'h97);

        // Two WHI back-to-back issue two writes
        base_we = we_count;
        bus_put(8'h07);
        bus_put(8'h49);
        bus_put(8'h4A);
        cpu_out = 8'h20;
        @(negedge clk);
        chk("b2b_count", 32'(we_count - base_we), 2);
        chk("b2b_last",  32'(last_wdata), 32'hA7);
        chk("b2b_mem",   32'(mem[12'h4B4]), 32'hA7);
        chk_nibbles("b2b_rbuf", 8'hA7);
        chk("no_overlap", 32'(overlap), 0);

        // 5-cycle memory, address changes during WAIT
        lat = 5;
        base_re = re_count;
        bus_put(8'hB3);
        cpu_out = 8'h20;
        @(negedge clk);
        @(negedge clk);
        bus_put(8'hB5);
        cpu_out = 8'h20;
        wait_idle(60);
        chk("chg_re_count", 32'(re_count - base_re), 2);
        chk("chg_re_addr",  32'(last_re_addr), 32'h4B5);
        chk_nibbles("chg_rbuf", 8'h5E);

        // Timeout: no return for 15 cycles in WAIT, then retry
        mute = 1'b1;
        bus_put(8'hB6);
        cpu_out = 8'h20;
        repeat (16) @(negedge clk);
        chk("to_not_yet", 32'(err_timeout), 0);
        @(negedge clk);
        chk("to_set", 32'(err_timeout), 1);
        @(negedge clk);
        chk("to_retry_re",   32'(mem_re), 1);
        chk("to_retry_addr", 32'(mem_addr), 32'h4B6);
        mute = 1'b0;
        wait_idle(60);
        chk("to_sticky", 32'(err_timeout), 1);
        chk_nibbles("to_rbuf", 8'h42);

        // One-cycle reset clears the error and the buffer
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_err",    32'(err_timeout), 0);
        chk("rst2_nibble", 32'(cpu_nibble), 0);
        @(negedge clk);
        chk("rst2_auto_re",   32'(mem_re), 1);
        chk("rst2_auto_addr", 32'(mem_addr), 32'h000);
        @(negedge clk);

        // Reset in WAIT, stale return arrives the cycle after
        mute = 1'b1;
        rst  = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        force_rv = 1'b1;
        @(negedge clk);
        force_rv = 1'b0;
        chk_nibbles("stale_rbuf", 8'h00);
        mute = 1'b0;
        base_re = re_count;
        wait_idle(60);
        chk("fresh_re_count", 32'(re_count - base_re), 1);
        chk("fresh_re_addr",  32'(last_re_addr), 32'h000);
        chk_nibbles("fresh_rbuf", 8'hA5);
        chk("fresh_err", 32'(err_timeout), 0);
        chk("final_no_overlap", 32'(overlap), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/moonbase_mem_bridge.md
# moonbase_mem_bridge

Synchronous bridge between the moonbase_cpu_8bit multiplexed 8-bit I/O bus and a single-port synchronous byte memory with a valid-flagged read return. Sits directly downstream of the CPU's `io_out`: it decodes the two-phase 12-bit address latch and the two-nibble write protocol. It keeps a one-byte read buffer coherent with the current address and feeds the CPU back the selected nibble on its `io_in[5:2]` field.

## Interface
- `ADDR_HALF`, 6: bits per address phase; address width is 2*ADDR_HALF (12).
- `TIMEOUT`, 15: max cycles spent in WAIT before abandoning a read; counter width is clog2(TIMEOUT+1).
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock, all state updates on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `cpu_out`  in  8  CPU `io_out`: [7] addr strobe, [6] phase/choose, [5] write enable (active low), [4] data strobe (ignored), [3:0] data; [5:0] carries address halves.
- `cpu_nibble`  out  4  nibble returned to CPU: `cpu_out[6]`=0 → `rbuf[7:4]`, =1 → `rbuf[3:0]`; combinational on `cpu_out[6]` and registered `rbuf`.
- `mem_addr`  out  12  registered address {addr_hi, addr_lo} for the command issued this cycle.
- `mem_wdata`  out  8  registered write byte.
- `mem_we`  out  1  one-cycle write command.
- `mem_re`  out  1  one-cycle read command.
- `mem_rdata`  in  8  read data, valid when `mem_rvalid`.
- `mem_rvalid`  in  1  read return, one cycle per `mem_re`, in order.
- `rd_busy`  out  1  high in REQ or WAIT, or while dirty is set.
- `err_timeout`  out  1  sticky; set when a read times out, cleared only by reset.

## Operation
- Bus decode at each rising edge:
  - ADDR_LO: `cpu_out[7]`=1, [6]=0 → addr_lo ← [5:0]; dirty ← 1.
  - ADDR_HI: [7]=1, [6]=1 → addr_hi ← [5:0]; dirty ← 1.
  - WLO: [7]=0, [5]=0, [6]=0 → wtmp ← [3:0].
  - WHI: [7]=0, [5]=0, [6]=1 → write commit.
  - All other codes: no action.
- Write commit:
  - Next cycle `mem_we`=1, `mem_addr`={addr_hi,addr_lo}, `mem_wdata`={[3:0],wtmp}.
  - Same edge: `rbuf` ← that byte (write-through).
  - A read currently in WAIT is marked discard.
- Read FSM states: IDLE, REQ, WAIT.
  - IDLE→REQ when dirty=1.
  - REQ drives `mem_re`=1 for one cycle with current address; dirty ← 0; → WAIT; timeout counter ← 0.
  - WAIT, `mem_rvalid`=1:
    - If discard=0 and dirty=0: `rbuf` ← `mem_rdata`.
    - Otherwise drop the data.
    - Clear discard; → IDLE, which re-enters REQ next cycle if dirty.
  - WAIT, counter reaches TIMEOUT with no `mem_rvalid`: `err_timeout` ← 1, → IDLE, dirty ← 1 (retry).
- Port arbitration: `mem_we` and `mem_re` never both high. A write commit coinciding with REQ wins; REQ holds one cycle and issues the read after.
- Address change during WAIT sets dirty. The stale return is dropped and a new read is issued.

## Timing
- Reset values:
  - addr_hi=addr_lo=0; wtmp=0; rbuf=0x00; FSM=IDLE; discard=0; counter=0.
  - dirty=1, so address 0 is read automatically after reset.
  - `mem_re`=`mem_we`=0; `mem_addr`=0; `mem_wdata`=0; `err_timeout`=0; `cpu_nibble`=0.
- Read latency:
  - Address latch edge N → REQ at N+1 → `mem_re` high during cycle N+2 → `rbuf` valid one edge after `mem_rvalid`.
  - With one-cycle memory, `rbuf` is updated at edge N+3.
- Write latency: WHI sampled at edge N → `mem_we` high during N+1; `rbuf` updated at N.
- Reset mid-read: FSM → IDLE, dirty=1. A `mem_rvalid` arriving in IDLE is ignored.
- Back-to-back WLO/WHI pairs every 2 cycles are sustained. Two WHI in consecutive cycles issue two writes.

## Test plan
- Reset, memory preloaded mem[0]=0xA5: `mem_re` pulse at addr 0x000; `rbuf`=0xA5; `cpu_nibble`=0xA with [6]=0, 0x5 with [6]=1.
- ADDR_HI 0x12, ADDR_LO 0x34, mem[0x4B4]=0x3C: one `mem_re` for the final address 0x4B4; `cpu_nibble` 0x3 then 0xC.
- WLO 0x7, WHI 0x9 at addr 0x4B4: `mem_we` one cycle, `mem_wdata`=0x97, `mem_addr`=0x4B4; `rbuf`=0x97 the same edge; `mem_re` never coincident.
- Memory with 5-cycle latency; change ADDR_LO during WAIT: first return dropped, second read issued to the new address, `rbuf` holds the new data.
- `mem_rvalid` held low: after TIMEOUT=15 cycles in WAIT, `err_timeout`=1 sticky and a retry `mem_re` issued; `rst` for one cycle clears it.
- `rst` asserted in WAIT with `mem_rvalid` arriving one cycle later: `rbuf`=0x00 unchanged by the stale data; fresh read of addr 0 follows.
